// File: rtl/bit64_seq_subtractor.sv
// rtl/bit64_seq_subtractor.sv - multi-cycle chunked subtractor (a - b) with compare flags
// One CHUNK of a + ~b + carry per RUN cycle; flags are registered alongside the final chunk.
module bit64_seq_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             lt,
  output logic             ltu
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_nb;
  logic [WIDTH-1:0]  r_diff;
  logic [IDXW-1:0]   r_idx;
  logic              r_carry;
  logic              r_borrow;
  logic              r_overflow;
  logic              r_zero;
  logic              r_lt;

  logic              w_accept;
  logic              w_last;
  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_nb_chunk;
  logic [CHUNK:0]    w_sum;
  logic [WIDTH-1:0]  w_diff_next;
  logic              w_a_msb;
  logic              w_b_msb;
  logic              w_d_msb;
  logic              w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_a_chunk  = r_a[r_idx*CHUNK +: CHUNK];
  assign w_nb_chunk = r_nb[r_idx*CHUNK +: CHUNK];
  assign w_sum      = {1'b0, w_a_chunk} + {1'b0, w_nb_chunk} + {{CHUNK{1'b0}}, r_carry};

  // Full result as it will look after this edge, so flags see the last chunk too.
  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end

  assign w_a_msb = r_a[WIDTH-1];
  assign w_b_msb = ~r_nb[WIDTH-1];
  assign w_d_msb = w_diff_next[WIDTH-1];
  assign w_ovf   = (w_a_msb != w_b_msb) && (w_d_msb != w_a_msb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_nb       <= '0;
      r_diff     <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_lt       <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_nb    <= ~b;
      r_carry <= 1'b1;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_diff  <= w_diff_next;
      r_carry <= w_sum[CHUNK];
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_borrow   <= ~w_sum[CHUNK];
        r_overflow <= w_ovf;
        r_zero     <= ~|w_diff_next;
        r_lt       <= w_d_msb ^ w_ovf;
      end
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign diff     = r_diff;
  assign borrow   = r_borrow;
  assign overflow = r_overflow;
  assign zero     = r_zero;
  assign lt       = r_lt;
  assign ltu      = r_borrow;

endmodule
